// File: rtl/register_file_pkg.sv
// register_file_pkg
//   Shared constants and types for the register file slice.
//   RF_DATA_W / RF_ADDR_W : default word width and index width
//   REG_ZERO              : index of the hardwired-zero register
//   clr_state_e           : bulk-clear sequencer state encoding
package register_file_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 3;
    localparam int REG_ZERO  = 0;

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } clr_state_e;

endpackage

// File: rtl/register_file_if.sv
// register_file_if
//   Bus bundle between the datapath and the register file.
//   Write port : WE, WADDR, WDATA
//   Read ports : RADDR_A/RDATA_A, RADDR_B/RDATA_B (combinational)
//   Clear      : CLR_REQ request, BUSY while the clear sequence runs
//   master = datapath side, slave = register file side.
interface register_file_if
    import register_file_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
);
    logic              WE;
    logic [ADDR_W-1:0] WADDR;
    logic [DATA_W-1:0] WDATA;
    logic [ADDR_W-1:0] RADDR_A;
    logic [ADDR_W-1:0] RADDR_B;
    logic [DATA_W-1:0] RDATA_A;
    logic [DATA_W-1:0] RDATA_B;
    logic              CLR_REQ;
    logic              BUSY;

    modport master (
        output WE, WADDR, WDATA, RADDR_A, RADDR_B, CLR_REQ,
        input  RDATA_A, RDATA_B, BUSY
    );

    modport slave (
        input  WE, WADDR, WDATA, RADDR_A, RADDR_B, CLR_REQ,
        output RDATA_A, RDATA_B, BUSY
    );
endinterface

// File: rtl/register_file_reg_word.sv
// register_file_reg_word
//   One falling-edge storage word.
//   clk_i  : clock, captured on the falling edge
//   rst_i  : synchronous active-high reset
//   clr_i  : synchronous clear (bulk-clear sequencer)
//   load_i : load enable for d_i
//   d_i    : write data
//   q_o    : stored word
//   Priority: reset, then clear, then load.
module register_file_reg_word
    import register_file_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] data_q;

    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (clr_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/register_file.sv
// register_file
//   8 x 16-bit register file, R0 hardwired to zero, two combinational read
//   ports with write-to-read bypass, one write port, and a sequenced bulk
//   clear of R1..R(NREG-1). All state changes on the falling edge of CLK.
//   CLK : clock (falling edge active)
//   RST : synchronous active-high reset
//   bus : register_file_if.slave (write, read A/B, CLR_REQ, BUSY)
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | normal operation, writes and bypass enabled, BUSY=0
//   CLEARING | zeroing reg[cnt_q] each edge, writes/requests ignored
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic           CLK,
    input  logic           RST,
    register_file_if.slave bus
);

    localparam int                NREG      = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX  = ADDR_W'(REG_ZERO);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NREG - 1);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy;
    logic              wr_ok;
    logic [DATA_W-1:0] word_q [NREG];

    assign busy  = (state_q == CLEARING);
    // A write is only real when idle and not aimed at R0; bypass follows it.
    assign wr_ok = bus.WE && !busy && (bus.WADDR != ZERO_IDX);

    always_ff @(negedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= FIRST_IDX;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.CLR_REQ) begin
                    state_d = CLEARING;
                    cnt_d   = FIRST_IDX;
                end
            end
            CLEARING: begin
                // The FSM leaves on the last index, so the counter never wraps.
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = FIRST_IDX;
                end else begin
                    cnt_d = cnt_q + FIRST_IDX;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = FIRST_IDX;
            end
        endcase
    end

    assign word_q[REG_ZERO] = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_word
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);
        register_file_reg_word #(
            .DATA_W (DATA_W)
        ) u_word (
            .clk_i  (CLK),
            .rst_i  (RST),
            .clr_i  (busy && (cnt_q == IDX)),
            .load_i (wr_ok && (bus.WADDR == IDX)),
            .d_i    (bus.WDATA),
            .q_o    (word_q[i])
        );
    end

    always_comb begin
        bus.RDATA_A = word_q[bus.RADDR_A];
        if (bus.RADDR_A == ZERO_IDX) begin
            bus.RDATA_A = '0;
        end else if (wr_ok && (bus.WADDR == bus.RADDR_A)) begin
            bus.RDATA_A = bus.WDATA;
        end
    end

    always_comb begin
        bus.RDATA_B = word_q[bus.RADDR_B];
        if (bus.RADDR_B == ZERO_IDX) begin
            bus.RDATA_B = '0;
        end else if (wr_ok && (bus.WADDR == bus.RADDR_B)) begin
            bus.RDATA_B = bus.WDATA;
        end
    end

    assign bus.BUSY = busy;

endmodule

// File: tb/tb_register_file.sv
// tb_register_file
//   Directed stimulus for register_file. A behavioural model (array of
//   register values plus "next index to clear") is checked against the DUT
//   every cycle, and literal expectations pin the key scenarios.
module tb_register_file;

    logic CLK;
    logic RST;

    register_file_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    register_file #(.DATA_W(16), .ADDR_W(3)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    initial begin
        CLK = 1'b1;
        forever #5 CLK = ~CLK;
    end

    // ---------------- behavioural model ----------------
    logic [15:0] mregs [8];
    int          mclr        = 0;      // 0: idle, else next register to zero
    bit          model_valid = 1'b0;

    always @(negedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
            mclr        = 0;
            model_valid = 1'b1;
        end else if (mclr != 0) begin
            mregs[mclr] = 16'h0000;
            mclr = (mclr == 7) ? 0 : mclr + 1;
        end else begin
            if (bus.WE && bus.WADDR != 3'd0) mregs[bus.WADDR] = bus.WDATA;
            if (bus.CLR_REQ) mclr = 1;
        end
    end

    function automatic logic [15:0] exp_rd(input logic [2:0] a);
        if (a == 3'd0) return 16'h0000;
        if (bus.WE && mclr == 0 && bus.WADDR == a) return bus.WDATA;
        return mregs[a];
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge CLK) begin
        #2;
        if (model_valid) begin
            chk("model_busy", {15'b0, bus.BUSY}, {15'b0, (mclr != 0)});
            chk("model_rdata_a", bus.RDATA_A, exp_rd(bus.RADDR_A));
            chk("model_rdata_b", bus.RDATA_B, exp_rd(bus.RADDR_B));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic rst, input logic we, input logic [2:0] wa,
                         input logic [15:0] wd, input logic [2:0] ra,
                         input logic [2:0] rb, input logic clr);
        @(posedge CLK);
        RST         = rst;
        bus.WE      = we;
        bus.WADDR   = wa;
        bus.WDATA   = wd;
        bus.RADDR_A = ra;
        bus.RADDR_B = rb;
        bus.CLR_REQ = clr;
        #3;
    endtask

    task automatic rd(input logic [2:0] ra, input logic [2:0] rb);
        drive(1'b0, 1'b0, 3'd0, 16'h0000, ra, rb, 1'b0);
    endtask

    task automatic wr(input logic [2:0] wa, input logic [15:0] wd);
        drive(1'b0, 1'b1, wa, wd, wa, 3'd0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int busy_cnt;

    initial begin
        RST = 1'b1;
        bus.WE = 1'b0; bus.WADDR = '0; bus.WDATA = '0;
        bus.RADDR_A = '0; bus.RADDR_B = '0; bus.CLR_REQ = 1'b0;

        // Reset, then every index reads zero on both ports
        drive(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), 3'(7 - i));
            chk("reset_a", bus.RDATA_A, 16'h0000);
            chk("reset_b", bus.RDATA_B, 16'h0000);
        end

        // Write R3, read back
        drive(1'b0, 1'b1, 3'd3, 16'h1234, 3'd3, 3'd0, 1'b0);
        chk("bypass_r3", bus.RDATA_A, 16'h1234);
        rd(3'd3, 3'd0);
        chk("read_r3", bus.RDATA_A, 16'h1234);
        chk("read_r0", bus.RDATA_B, 16'h0000);

        // R0 protection
        drive(1'b0, 1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 1'b0);
        chk("r0_nobypass", bus.RDATA_A, 16'h0000);
        rd(3'd0, 3'd0);
        chk("r0_after", bus.RDATA_B, 16'h0000);

        // Bypass on R5
        drive(1'b0, 1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd3, 1'b0);
        chk("bypass_r5", bus.RDATA_A, 16'hBEEF);
        chk("r3_kept", bus.RDATA_B, 16'h1234);
        rd(3'd5, 3'd5);
        chk("read_r5_a", bus.RDATA_A, 16'hBEEF);
        chk("read_r5_b", bus.RDATA_B, 16'hBEEF);

        // Clear sequence with R1..R7 = 0x0011..0x0077
        for (int i = 1; i < 8; i++) wr(3'(i), 16'(i * 17));
        drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd4, 1'b1);
        chk("clr_busy_pre", {15'b0, bus.BUSY}, 16'h0000);
        busy_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            rd(3'd3, 3'd4);
            if (bus.BUSY) busy_cnt++;
            if (k == 4) begin
                chk("clr3_r3", bus.RDATA_A, 16'h0000);
                chk("clr3_r4", bus.RDATA_B, 16'h0044);
            end
            if (!bus.BUSY && busy_cnt > 0) break;
        end
        chk("clr_busy_len", 16'(busy_cnt), 16'd7);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), 3'(i));
            chk("clr_all_a", bus.RDATA_A, 16'h0000);
            chk("clr_all_b", bus.RDATA_B, 16'h0000);
        end

        // Write and clear request while busy
        wr(3'd7, 16'h0077);
        drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd7, 3'd0, 1'b1);
        busy_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin
                drive(1'b0, 1'b1, 3'd7, 16'hAAAA, 3'd7, 3'd0, 1'b1);
                chk("busy_nobypass", bus.RDATA_A, 16'h0077);
            end else begin
                rd(3'd7, 3'd0);
            end
            if (bus.BUSY) busy_cnt++;
            if (!bus.BUSY && busy_cnt > 0) break;
        end
        chk("busy_norestart", 16'(busy_cnt), 16'd7);
        chk("busy_r7_zero", bus.RDATA_A, 16'h0000);

        // Reset during clear edge 4
        wr(3'd2, 16'h2222);
        wr(3'd6, 16'h6666);
        drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd6, 3'd2, 1'b1);
        rd(3'd6, 3'd2);
        rd(3'd6, 3'd2);
        rd(3'd6, 3'd2);
        chk("midclr_r6_old", bus.RDATA_A, 16'h6666);
        drive(1'b1, 1'b0, 3'd0, 16'h0, 3'd6, 3'd2, 1'b0);
        drive(1'b0, 1'b1, 3'd2, 16'h5555, 3'd6, 3'd1, 1'b0);
        chk("rst_busy", {15'b0, bus.BUSY}, 16'h0000);
        chk("rst_r6", bus.RDATA_A, 16'h0000);
        chk("rst_r1", bus.RDATA_B, 16'h0000);
        rd(3'd2, 3'd2);
        chk("rst_write_r2", bus.RDATA_A, 16'h5555);

        // Same-edge clear request and write in idle
        drive(1'b0, 1'b1, 3'd6, 16'h0606, 3'd6, 3'd2, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            rd(3'd6, 3'd2);
            if (k <= 6) chk("same_edge_r6_held", bus.RDATA_A, 16'h0606);
            else        chk("same_edge_r6_zero", bus.RDATA_A, 16'h0000);
        end
        for (int k = 0; k < 4; k++) rd(3'd6, 3'd0);
        chk("same_edge_idle", {15'b0, bus.BUSY}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
